// File: rtl/pixel_window_streamer.sv
// pixel_window_streamer: raster pixel stream to 3x3 windows with optional zero-pad border
module pixel_window_streamer #(
  parameter int PIXEL_W     = 8,
  parameter int IMG_W       = 512,
  parameter int IMG_H       = 512,
  parameter int BORDER_MODE = 0
) (
  input  logic                       clk,
  input  logic                       rstN,
  input  logic [PIXEL_W-1:0]         pixel_in,
  input  logic                       pixel_in_valid,
  output logic                       pixel_in_ready,
  output logic [9*PIXEL_W-1:0]       window_out,
  output logic                       window_out_valid,
  input  logic                       window_out_ready,
  output logic [$clog2(IMG_H)-1:0]   out_row,
  output logic [$clog2(IMG_W)-1:0]   out_col,
  output logic                       frame_done
);
  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);
  localparam logic [XW-1:0] XMAX   = XW'(IMG_W - 1);
  localparam logic [YW-1:0] YMAX   = YW'(IMG_H - 1);
  localparam logic [YW-1:0] FD_ROW = YW'(BORDER_MODE != 0 ? IMG_H - 1 : IMG_H - 2);
  localparam logic [XW-1:0] FD_COL = XW'(BORDER_MODE != 0 ? IMG_W - 1 : IMG_W - 2);

  typedef enum logic [1:0] {STREAM, ROW_END, FLUSH} state_t;
  state_t state, state_nx;

  logic [YW-1:0]      row, nrow;
  logic [XW-1:0]      col, fcol, rd, ncol;
  logic [PIXEL_W-1:0] lb1 [IMG_W];
  logic [PIXEL_W-1:0] lb2 [IMG_W];
  logic [PIXEL_W-1:0] c0 [3];
  logic [PIXEL_W-1:0] c1 [3];
  logic [PIXEL_W-1:0] cn [3];
  logic               out_free, in_fire, out_fire, emit, load, shift;
  logic [9*PIXEL_W-1:0] nwin;

  assign out_free       = !window_out_valid || window_out_ready;
  assign pixel_in_ready = (state == STREAM) && out_free;
  assign in_fire        = pixel_in_valid && pixel_in_ready;
  assign out_fire       = window_out_valid && window_out_ready;

  // c0/c1 hold the two previous columns, cn is the column being read now (top, mid, bottom)
  always_comb begin
    emit  = BORDER_MODE != 0 ? (row != '0 && col != '0) : (row > YW'(1) && col > XW'(1));
    rd    = state == STREAM ? col : state == ROW_END ? '0 : (fcol == XMAX ? '0 : fcol + XW'(1));
    cn[0] = lb2[rd];
    cn[1] = lb1[rd];
    cn[2] = pixel_in;
    load  = state == STREAM ? in_fire && emit : out_free;
    shift = state == STREAM ? in_fire : out_free;
    nrow  = state == STREAM ? row - YW'(1) : state == ROW_END ? out_row : YMAX;
    ncol  = state == STREAM ? col - XW'(1) : state == ROW_END ? XMAX : fcol;
  end

  // border taps are zeroed from the centre coordinates, never from buffer contents
  always_comb begin
    nwin = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        nwin[(r*3+c)*PIXEL_W +: PIXEL_W] =
          ((r == 0 && nrow == '0) || (r == 2 && nrow == YMAX) ||
           (c == 0 && ncol == '0) || (c == 2 && ncol == XMAX)) ? '0 :
          c == 0 ? c0[r] : c == 1 ? c1[r] : cn[r];
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      STREAM:  state_nx = (in_fire && BORDER_MODE != 0 && col == XMAX && row != '0) ? ROW_END : STREAM;
      ROW_END: state_nx = out_free ? (row == '0 ? FLUSH : STREAM) : ROW_END;
      FLUSH:   state_nx = (out_free && fcol == XMAX) ? STREAM : FLUSH;
      default: state_nx = STREAM;
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state            <= STREAM;
      row              <= '0;
      col              <= '0;
      fcol             <= '0;
      window_out       <= '0;
      window_out_valid <= 1'b0;
      out_row          <= '0;
      out_col          <= '0;
      frame_done       <= 1'b0;
    end else begin
      state <= state_nx;
      if (in_fire) begin
        col <= col == XMAX ? '0 : col + XW'(1);
        if (col == XMAX) row <= row == YMAX ? '0 : row + YW'(1);
      end
      if (state == FLUSH && out_free) fcol <= fcol == XMAX ? '0 : fcol + XW'(1);
      if (load) begin
        window_out       <= nwin;
        out_row          <= nrow;
        out_col          <= ncol;
        window_out_valid <= 1'b1;
      end else if (window_out_ready) begin
        window_out_valid <= 1'b0;
      end
      frame_done <= out_fire && out_row == FD_ROW && out_col == FD_COL;
    end
  end

  always_ff @(posedge clk) begin
    if (in_fire) begin
      lb1[col] <= pixel_in;
      lb2[col] <= lb1[col];
    end
    if (shift) begin
      c0 <= c1;
      c1 <= cn;
    end
  end
endmodule

// File: tb/tb_pixel_window_streamer.sv
// tb_pixel_window_streamer: valid-only and zero-pad instances on a 4x3 image against a 3x3 reference model
module tb_pixel_window_streamer;
  localparam int W = 4;
  localparam int H = 3;

  logic clk = 1'b0;
  logic rstN = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]  pix_in    [2];
  logic        in_valid  [2];
  logic        in_ready  [2];
  logic [71:0] win       [2];
  logic        out_valid [2];
  logic        out_ready [2];
  logic [1:0]  orow      [2];
  logic [1:0]  ocol      [2];
  logic        frame_done[2];

  int passed = 0;
  int total = 0;
  logic [7:0]  pix [2][$];
  logic [75:0] q   [2][$];
  logic [71:0] obs [2][$];
  logic [7:0]  img [H][W];
  int          win_cnt[2], fd_cnt[2], stalls[2];
  logic        hold[2], fd_exp[2];
  logic [75:0] held[2];

  pixel_window_streamer #(.PIXEL_W(8), .IMG_W(W), .IMG_H(H), .BORDER_MODE(0)) u0 (
    .clk(clk), .rstN(rstN), .pixel_in(pix_in[0]), .pixel_in_valid(in_valid[0]),
    .pixel_in_ready(in_ready[0]), .window_out(win[0]), .window_out_valid(out_valid[0]),
    .window_out_ready(out_ready[0]), .out_row(orow[0]), .out_col(ocol[0]),
    .frame_done(frame_done[0]));

  pixel_window_streamer #(.PIXEL_W(8), .IMG_W(W), .IMG_H(H), .BORDER_MODE(1)) u1 (
    .clk(clk), .rstN(rstN), .pixel_in(pix_in[1]), .pixel_in_valid(in_valid[1]),
    .pixel_in_ready(in_ready[1]), .window_out(win[1]), .window_out_valid(out_valid[1]),
    .window_out_ready(out_ready[1]), .out_row(orow[1]), .out_col(ocol[1]),
    .frame_done(frame_done[1]));

  task automatic chk(input string tag, input int m, input logic [79:0] o, input logic [79:0] e);
    total++;
    assert (o === e) passed++;
    else $error("FAIL %s (mode %0d): got %0h, expected %0h", tag, m, o, e);
  endtask

  // one image, fed to both instances; expected windows follow the zero-pad 3x3 definition directly
  task automatic gen_frame(input int kind);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        img[y][x] = kind == 0 ? 8'(16*y + x) : 8'($urandom);
    for (int m = 0; m < 2; m++) begin
      for (int y = 0; y < H; y++)
        for (int x = 0; x < W; x++) pix[m].push_back(img[y][x]);
      for (int cy = 0; cy < H; cy++)
        for (int cx = 0; cx < W; cx++)
          if (m == 1 || (cy >= 1 && cy <= H-2 && cx >= 1 && cx <= W-2)) begin
            logic [71:0] w;
            w = '0;
            for (int r = 0; r < 3; r++)
              for (int c = 0; c < 3; c++) begin
                int yy, xx;
                yy = cy + r - 1;
                xx = cx + c - 1;
                if (yy >= 0 && yy < H && xx >= 0 && xx < W) w[(r*3+c)*8 +: 8] = img[yy][xx];
              end
            q[m].push_back({2'(cy), 2'(cx), w});
          end
    end
  endtask

  task automatic run(input int m, input int vpct, input int rpat, input int stop);
    int acc, cyc, tail;
    acc = 0; cyc = 0; tail = 0;
    stalls[m] = 0;
    while (cyc < 2000) begin
      @(posedge clk); #1;
      out_ready[m] = rpat == 0 ? 1'b1 : rpat == 1 ? (cyc % 4 == 0 || cyc % 4 == 3) : ($urandom_range(99) < 70);
      in_valid[m]  = pix[m].size() != 0 && (stop == 0 || acc < stop) && $urandom_range(99) < vpct;
      pix_in[m]    = in_valid[m] ? pix[m][0] : 8'($urandom);
      @(negedge clk);
      if (!in_ready[m]) stalls[m]++;
      if (in_valid[m] && in_ready[m]) begin
        void'(pix[m].pop_front());
        acc++;
      end
      cyc++;
      if (stop != 0 && acc == stop) break;
      if (stop == 0 && pix[m].size() == 0 && q[m].size() == 0) begin
        tail++;
        if (tail > 2) break;
      end
    end
    chk("run_timeout", m, 80'(cyc < 2000), 80'(1));
    @(posedge clk); #1;
    in_valid[m]  = 1'b0;
    out_ready[m] = 1'b1;
  endtask

  task automatic clear_stats();
    for (int m = 0; m < 2; m++) begin
      win_cnt[m] = 0;
      fd_cnt[m]  = 0;
      obs[m].delete();
    end
  endtask

  task automatic end_checks(input int frames);
    for (int m = 0; m < 2; m++) begin
      chk("window_count", m, 80'(win_cnt[m]), 80'(frames * (m == 1 ? W*H : (W-2)*(H-2))));
      chk("frame_done_count", m, 80'(fd_cnt[m]), 80'(frames));
      chk("leftover_windows", m, 80'(q[m].size()), 80'(0));
    end
  endtask

  always @(negedge clk)
    for (int m = 0; m < 2; m++) begin : mon
      logic [75:0] cur;
      logic fire;
      if (!rstN) begin
        hold[m]   = 1'b0;
        fd_exp[m] = 1'b0;
      end else begin
        cur  = {orow[m], ocol[m], win[m]};
        fire = out_valid[m] && out_ready[m];
        chk("frame_done_timing", m, 80'(frame_done[m]), 80'(fd_exp[m]));
        if (frame_done[m]) fd_cnt[m]++;
        if (hold[m]) chk("stall_hold", m, 80'({out_valid[m], cur}), 80'({1'b1, held[m]}));
        if (out_valid[m] && !out_ready[m]) chk("in_ready_backpressure", m, 80'(in_ready[m]), 80'(0));
        if (fire) begin
          win_cnt[m]++;
          obs[m].push_back(win[m]);
          chk("window_expected", m, 80'(q[m].size() != 0), 80'(1));
          if (q[m].size() != 0) chk("window", m, 80'(cur), 80'(q[m].pop_front()));
        end
        fd_exp[m] = fire && orow[m] == (m == 1 ? 2'd2 : 2'd1) && ocol[m] == (m == 1 ? 2'd3 : 2'd2);
        hold[m]   = out_valid[m] && !out_ready[m];
        held[m]   = cur;
      end
    end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    for (int m = 0; m < 2; m++) begin
      in_valid[m] = 1'b0; out_ready[m] = 1'b1; pix_in[m] = '0;
    end
    clear_stats();
    repeat (3) @(posedge clk);
    #1;
    for (int m = 0; m < 2; m++) begin
      chk("reset_valid", m, 80'(out_valid[m]), 80'(0));
      chk("reset_window", m, 80'(win[m]), 80'(0));
      chk("reset_coords", m, 80'({orow[m], ocol[m]}), 80'(0));
      chk("reset_frame_done", m, 80'(frame_done[m]), 80'(0));
    end
    rstN = 1'b1;

    // ramp frame, no bubbles, no backpressure
    gen_frame(0);
    fork run(0, 100, 0, 0); run(1, 100, 0, 0); join
    end_checks(1);
    chk("stall_cycles", 0, 80'(stalls[0]), 80'(0));
    chk("stall_cycles", 1, 80'(stalls[1]), 80'(6));
    chk("centre_1_1", 0, 80'(obs[0][0]), 80'({8'h22, 8'h21, 8'h20, 8'h12, 8'h11, 8'h10, 8'h02, 8'h01, 8'h00}));
    chk("centre_1_2", 0, 80'(obs[0][1]), 80'({8'h23, 8'h22, 8'h21, 8'h13, 8'h12, 8'h11, 8'h03, 8'h02, 8'h01}));
    chk("centre_0_0", 1, 80'(obs[1][0]), 80'({8'h11, 8'h10, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}));
    chk("centre_2_3", 1, 80'(obs[1][11]), 80'({8'h00, 8'h00, 8'h00, 8'h00, 8'h23, 8'h22, 8'h00, 8'h13, 8'h12}));

    // output backpressure 1-0-0-1
    clear_stats();
    gen_frame(0);
    fork run(0, 100, 1, 0); run(1, 100, 1, 0); join
    end_checks(1);

    // random data, input bubbles and random backpressure
    clear_stats();
    gen_frame(1);
    fork run(0, 50, 2, 0); run(1, 50, 2, 0); join
    end_checks(1);

    // two frames back to back
    clear_stats();
    gen_frame(1);
    gen_frame(1);
    fork run(0, 100, 0, 0); run(1, 100, 0, 0); join
    end_checks(2);

    // reset after 6 pixels, then a clean random frame
    gen_frame(0);
    fork run(0, 100, 0, 6); run(1, 100, 0, 6); join
    @(posedge clk); #2;
    rstN = 1'b0;
    #1;
    for (int m = 0; m < 2; m++) begin
      chk("midreset_valid", m, 80'(out_valid[m]), 80'(0));
      chk("midreset_window", m, 80'(win[m]), 80'(0));
      chk("midreset_coords", m, 80'({orow[m], ocol[m]}), 80'(0));
      pix[m].delete();
      q[m].delete();
    end
    repeat (2) @(posedge clk);
    #1;
    rstN = 1'b1;
    clear_stats();
    gen_frame(1);
    fork run(0, 100, 2, 0); run(1, 70, 0, 0); join
    end_checks(1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
